pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer.
- Consumes the branch/jump target produced by the PC+immediate target adder in execute.
- Drives the instruction-memory request/response handshake and presents one fetched instruction at a time, with its PC, to decode.
- Handles redirects arriving at any point of an outstanding fetch and discards wrong-path responses.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- INSTR_BYTES, 4, PC increment per sequential fetch.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- branch_taken  input  1  redirect request from execute, single-cycle pulse.
- branch_target  input  32  redirect address (target adder output); bits [1:0] are ignored and treated as 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; word aligned.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; exactly one per granted request, at least 1 cycle after the grant.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
- instr  output  32  fetched instruction.
- instr_pc  output  32  address the instruction was fetched from.
- instr_ready  input  1  decode accepts instr this cycle.

Behaviour:
- Registers: pc, state, flush, redir_pc, instr, instr_pc, instr_valid. All outputs come from registers or state decode; there are no combinational input-to-output paths.
- Reset values while rst is high: state=IDLE, pc=RESET_PC, flush=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Reset deassertion mid-transaction abandons the transaction. The memory side must also be reset; no response is tracked across reset.
- State machine transitions:
  - IDLE: go to REQ on the next edge, unconditionally. The first imem_req is therefore in the 2nd cycle after rst falls.
  - REQ: imem_req=1, imem_addr=pc.
    - imem_addr is held stable until imem_gnt, even if a redirect arrives.
    - On imem_gnt go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - flush=1: discard the data, set pc=redir_pc, clear flush, go to REQ.
    - flush=0: set instr=imem_rdata, instr_pc=pc, pc=pc+INSTR_BYTES, instr_valid=1, go to HOLD.
  - HOLD: instr_valid=1, imem_req=0.
    - branch_taken: drop the instruction (instr_valid=0), set pc={branch_target[31:2],2'b00}, go to REQ.
    - Else instr_ready: transfer completes, instr_valid=0, go to REQ.
    - Else hold all outputs stable.
- Redirect handling:
  - branch_taken in REQ or WAIT sets flush=1 and redir_pc={branch_target[31:2],2'b00}.
  - Multiple redirects before resolution: the last one wins.
  - branch_taken in the same cycle as imem_rvalid in WAIT: the response is discarded and the next request goes to the new target.
  - branch_taken in the same cycle as imem_gnt in REQ: flush=1 and the state moves to WAIT, so the granted response is discarded later.
  - branch_taken in IDLE: pc=target, then REQ.
- Priority: in HOLD, branch_taken outranks instr_ready. A coincident ready is not a transfer; the wrong-path instruction is dropped.
- Arithmetic: pc+INSTR_BYTES is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Latency and throughput:
  - Request to instruction valid is grant latency + response latency + 1 cycle.
  - One request is outstanding at most.
  - Minimum steady-state rate is 1 instruction per 3 cycles (REQ, WAIT, HOLD) with 0-wait memory and instr_ready held at 1.

Test Plan:
- Reset release, RESET_PC=0, gnt tied 1, rvalid 1 cycle after gnt, instr_ready=1 -> imem_addr 0x0, 0x4, 0x8 in sequence. instr_pc matches each address and instr equals the memory word.
- gnt withheld 3 cycles, then branch_taken with target 0x100 before gnt -> imem_addr stays 0x0 until gnt. Response dropped (instr_valid stays 0). Next request at 0x100.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_valid, instr and instr_pc stable; no imem_req until ready.
- branch_taken target 0x203 coincident with imem_rvalid -> rdata dropped; next imem_addr 0x200. Then branch_taken with instr_ready=1 in HOLD -> instruction not transferred; request at the new target.
- pc=0xFFFF_FFFC fetched and accepted -> next imem_addr 0x0000_0000.
- rst asserted for 1 cycle while in WAIT -> outputs immediately take reset values; after release the first request is at RESET_PC in the 2nd cycle.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction-fetch sequencer.
// Wrong-path responses are dropped via a flush flag and a pending redirect address.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic        flush;
    logic [31:0] tgt;

    assign tgt = {branch_target[31:2], 2'b00};

    // pc only moves outside REQ, so the address stays stable until granted
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            redir_pc    <= RESET_PC;
            flush       <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_taken)
                        pc <= tgt;
                    state <= REQ;
                end
                REQ: begin
                    if (branch_taken) begin
                        flush    <= 1'b1;
                        redir_pc <= tgt;
                    end
                    if (imem_gnt)
                        state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (branch_taken) begin
                            pc    <= tgt;
                            flush <= 1'b0;
                            state <= REQ;
                        end else if (flush) begin
                            pc    <= redir_pc;
                            flush <= 1'b0;
                            state <= REQ;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            pc          <= pc + PC_STEP;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (branch_taken) begin
                        flush    <= 1'b1;
                        redir_pc <= tgt;
                    end
                end
                HOLD: begin
                    // a redirect kills the held instruction even if decode is ready
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        pc          <= tgt;
                        state       <= REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
